// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: a valid/ready request carrying a
// memory or branch offset plus register fields, and a valid/ready response
// carrying the encoded RV64 instruction word.
interface imm_encoder_if #(
  parameter int unsigned N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_kind;
  logic [N-1:0] in_imm;
  logic [4:0]   in_rs1;
  logic [4:0]   in_rs2;
  logic [4:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_inst;
  logic         out_err;

  // Request producer / response consumer side
  modport master (
    output in_valid, in_kind, in_imm, in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  // Encoder side
  modport slave (
    input  in_valid, in_kind, in_imm, in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 captures an accepted request, S2 holds the
// encoded ld/sd/beq word (or a NOP flagged with out_err when the offset does
// not fit the format or the kind is reserved) and presents it downstream.
module imm_encoder #(
  parameter int unsigned N = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  imm_encoder_if.slave bus,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    KIND_LD  = 2'b00,
    KIND_SD  = 2'b01,
    KIND_BEQ = 2'b10,
    KIND_RSV = 2'b11
  } kind_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic         s1_valid;
  kind_e        s1_kind;
  logic [N-1:0] s1_imm;
  logic [4:0]   s1_rs1;
  logic [4:0]   s1_rs2;
  logic [4:0]   s1_rd;

  logic         s2_valid;
  logic [31:0]  s2_inst;
  logic         s2_err;

  logic         s2_load;
  logic         s1_load;
  logic         fits12;
  logic         fits13;
  logic [31:0]  enc_inst;
  logic         enc_err;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  assign bus.out_valid = s2_valid;
  assign bus.out_inst  = s2_inst;
  assign bus.out_err   = s2_err;

  // Offset fits when all bits above the format's sign bit replicate it
  assign fits12 = (&s1_imm[N-1:11]) | ~(|s1_imm[N-1:11]);
  assign fits13 = (&s1_imm[N-1:12]) | ~(|s1_imm[N-1:12]);

  // S1: capture the request whenever the slot is free or draining forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_kind  <= KIND_LD;
      s1_imm   <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_rd    <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_kind <= kind_e'(bus.in_kind);
        s1_imm  <= bus.in_imm;
        s1_rs1  <= bus.in_rs1;
        s1_rs2  <= bus.in_rs2;
        s1_rd   <= bus.in_rd;
      end
    end
  end

  // Encode the S1 request; anything unencodable becomes a flagged NOP
  always_comb begin
    enc_inst = NOP_INST;
    enc_err  = 1'b1;
    unique case (s1_kind)
      KIND_LD: begin
        if (fits12) begin
          enc_inst = {s1_imm[11:0], s1_rs1, 3'b011, s1_rd, 7'b0000011};
          enc_err  = 1'b0;
        end
      end
      KIND_SD: begin
        if (fits12) begin
          enc_inst = {s1_imm[11:5], s1_rs2, s1_rs1, 3'b011, s1_imm[4:0], 7'b0100011};
          enc_err  = 1'b0;
        end
      end
      KIND_BEQ: begin
        if (fits13 && !s1_imm[0]) begin
          enc_inst = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, 3'b000,
                      s1_imm[4:1], s1_imm[11], 7'b1100011};
          enc_err  = 1'b0;
        end
      end
      KIND_RSV: begin
        enc_inst = NOP_INST;
        enc_err  = 1'b1;
      end
      default: begin
        enc_inst = NOP_INST;
        enc_err  = 1'b1;
      end
    endcase
  end

  // S2: output register, frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_inst  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_inst <= enc_inst;
        s2_err  <= enc_err;
      end
    end
  end

  // Saturating count of error words actually handed downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (s2_valid && bus.out_ready && s2_err && (err_count != '1)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter N, default 64, SHALL set the width of the input immediate.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request presented.
REQ-005 in_ready  output  1  request accepted when in_valid && in_ready at the clock edge.
REQ-006 in_kind  input  2  00 load (ld), 01 store (sd), 10 branch (beq), 11 reserved.
REQ-007 in_imm  input  N  signed byte offset.
REQ-008 in_rs1, in_rs2, in_rd  input  5 each  register fields; fields unused by a format are ignored.
REQ-009 out_valid  output  1  encoded word available.
REQ-010 out_ready  input  1  word consumed when out_valid && out_ready at the clock edge.
REQ-011 out_inst  output  32  encoded RV64 instruction word.
REQ-012 out_err  output  1  qualifies out_inst as a substituted NOP caused by an invalid request.
REQ-013 err_count  output  16  count of delivered error words.

Function
REQ-014 Two-stage pipeline: S1 registers the accepted request; S2 holds the encoded word and drives out_*.
REQ-015 Latency SHALL be exactly 2 cycles from acceptance to out_valid with out_ready held high; throughput SHALL be 1 word/cycle.
REQ-016 S2 loads when !s2_valid || out_ready; S1 loads when !s1_valid || S2 loads; in_ready = !s1_valid || S2 loads (combinational from out_ready is permitted).
REQ-017 Words SHALL leave in acceptance order; no request SHALL be dropped or duplicated under any backpressure pattern.
REQ-018 out_inst, out_err SHALL hold stable while out_valid && !out_ready.
REQ-019 Load: inst[31:20]=imm[11:0], [19:15]=rs1, [14:12]=3'b011, [11:7]=rd, [6:0]=7'b0000011.
REQ-020 Store: inst[31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=3'b011, [11:7]=imm[4:0], [6:0]=7'b0100011.
REQ-021 Branch: inst[31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=3'b000, [11:8]=imm[4:1], [7]=imm[11], [6:0]=7'b1100011.
REQ-022 Load/store valid iff in_imm[N-1:11] all equal (range -2048..2047).
REQ-023 Branch valid iff in_imm[N-1:12] all equal and in_imm[0]==0 (even, range -4096..4094).
REQ-024 in_kind 11 SHALL be invalid.
REQ-025 Invalid request: out_inst SHALL be 32'h00000013, out_err SHALL be 1; otherwise out_err SHALL be 0.
REQ-026 err_count SHALL increment by 1 on each out_valid && out_ready && out_err, saturating at 16'hFFFF.
REQ-027 Range check and encoding SHALL use the value captured in S1, not live inputs.

Reset
REQ-028 rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid, out_err, err_count and set out_inst to 32'h0, independent of clk.
REQ-029 Reset mid-operation SHALL discard all in-flight requests; no word SHALL emerge after deassertion unless newly accepted.
REQ-030 in_ready SHALL be 1 during reset and on the first cycle after deassertion.

Verification
REQ-031 Load kind 00, imm -8, rs1 10, rd 5, out_ready 1 -> out_inst 32'hFF853283, out_err 0, out_valid exactly 2 cycles after acceptance.
REQ-032 Store kind 01, imm 16, rs1 2, rs2 6 -> out_inst 32'h00613823; branch kind 10, imm -4, rs1 1, rs2 2 -> 32'hFE208EE3.
REQ-033 Load imm 2048, branch imm 3, kind 11 back-to-back -> three words 32'h00000013 with out_err 1; err_count 0 -> 3.
REQ-034 out_ready low, 3 requests offered -> 2 accepted, in_ready 0 on third; out_inst stable; out_ready high -> all 3 delivered in order, one per cycle.
REQ-035 rst_n pulsed low with both stages full -> out_valid 0 immediately, err_count 0, nothing emitted afterwards until a new request.
REQ-036 Random valid/ready stress vs. reference model -> all words match, in order, error count equal.
